conv_2d_ctrl: RTL and testbench
===============================

Name: conv_2d_ctrl

Overview:
- Sequencer for the 3x3 convolution datapath (conv_2d).
- Loads the 3x3 kernel through the datapath's 3-lane shared data port.
- Streams image columns as 3-row strips, one column of 3 pixels per beat, and inserts the end-of-strip flush column.
- Produces a window-valid strobe and column index aligned with the datapath's registered o_pixel.

Parameters:
IMG_W, 640, columns per strip (>=3)
NUM_STRIPS, 478, strips per frame (>=1)
COL_W, $clog2(IMG_W+1), width of column counters/index
STRIP_W, $clog2(NUM_STRIPS+1), width of strip counter

Ports:
clk  in  1  system clock
i_rst  in  1  synchronous reset, active-high; datapath reset is driven as ~i_rst at top level
i_knl_start  in  1  pulse: begin kernel load
i_knl_valid  in  1  kernel column valid
i_knl_c1/c2/c3  in  8 each  signed coefficients, kernel rows 1/2/3 of current column
o_knl_ready  out  1  kernel column accepted when valid&ready
i_frame_start  in  1  pulse: begin frame
i_pix_valid  in  1  pixel column valid
i_pix1/2/3  in  8 each  pixels, strip rows 1/2/3
o_pix_ready  out  1  pixel column accepted when valid&ready
o_load_knl  out  1  to datapath i_load_knl
o_en_conv  out  1  to datapath i_en_conv
o_data1/2/3  out  8 each  to datapath i_data1/2/3
o_win_valid  out  1  datapath o_pixel holds a full 3x3 window this cycle
o_win_col  out  COL_W  leftmost column of that window
o_strip_done  out  1  one-cycle pulse, strip finished
o_frame_done  out  1  one-cycle pulse, frame finished
o_knl_loaded  out  1  kernel resident
o_busy  out  1  state != IDLE

Behaviour:
- Reset: all outputs 0, state IDLE, all counters 0, o_knl_loaded=0.
- Reset mid-operation aborts immediately; the kernel must be reloaded before the next frame.
- All datapath-facing outputs (o_load_knl, o_en_conv, o_data*) are registered. A beat accepted at edge t is presented to the datapath during cycle t+1.
- o_load_knl and o_en_conv are never high together.
- States: IDLE, LOAD, LOAD_WRAP, RUN, FLUSH, DONE.
- IDLE transitions:
  - i_knl_start -> LOAD.
  - i_frame_start with o_knl_loaded=1 -> RUN, strip_cnt=0.
  - i_frame_start with o_knl_loaded=0 is ignored.
  - Both start pulses in the same cycle: LOAD wins.
- LOAD:
  - o_knl_ready=1; o_knl_loaded cleared on entry.
  - Each accepted column k (0..2) produces one cycle of o_load_knl=1 with o_data=c1/c2/c3.
  - Cycles with no valid column produce o_load_knl=0, which holds the datapath load counter.
  - After the 3rd acceptance -> LOAD_WRAP.
- LOAD_WRAP:
  - o_knl_ready=0.
  - Emits exactly one extra o_load_knl=1 cycle with o_data=0. This returns the datapath load counter from 3 to 0.
  - Then IDLE, o_knl_loaded=1.
  - Total: exactly 4 o_load_knl cycles per load.
- RUN:
  - o_pix_ready=1 while col_cnt<IMG_W.
  - Each acceptance produces o_en_conv=1 with o_data=pixels, and col_cnt++.
  - Gaps produce o_en_conv=0, so the datapath window holds.
  - When col_cnt reaches IMG_W -> FLUSH.
- FLUSH:
  - o_pix_ready=0.
  - One o_en_conv=1 cycle with o_data=0; this clocks out the last window.
  - Then col_cnt=0 and o_strip_done pulses.
  - If strip_cnt==NUM_STRIPS-1 -> DONE; else strip_cnt++ and -> RUN.
- DONE: o_frame_done pulses for 1 cycle, then IDLE.
- Start pulses during LOAD/RUN/FLUSH are ignored.
- Datapath contract: an o_en_conv cycle registers in o_pixel the window that was present before that cycle's column entered.
- Window tracking:
  - issued = number of o_en_conv cycles so far in the strip, counted before the current one.
  - If o_en_conv=1 with issued>=3, the next cycle has o_win_valid=1 and o_win_col=issued-3.
  - Otherwise o_win_valid=0.
  - The first 3 issues of each strip produce no valid window; this discards stale columns from the previous strip.
  - Per strip: IMG_W+1 issues, IMG_W-2 valid windows, o_win_col = 0..IMG_W-3.

Test Plan:
1. Kernel load: columns (1,4,7),(2,5,8),(3,6,9) back-to-back -> o_load_knl high 4 consecutive cycles; datapath model kernel[1..9]=1..9; o_knl_loaded=1 after the wrap cycle.
2. Kernel load with a 2-cycle valid gap after column 0 -> o_load_knl low during the gap; same final kernel; exactly 4 load cycles.
3. Frame start before any kernel load -> no state change, o_pix_ready stays 0.
4. IMG_W=5, NUM_STRIPS=2, identity kernel (center=1), continuous pixels -> per strip: 5 accepts + 1 flush; o_win_valid 3 times with o_win_col 0,1,2; o_pixel equals the middle-row pixel of the centre column (cols 1,2,3); 2 o_strip_done pulses, 1 o_frame_done.
5. Same as 4 with random i_pix_valid gaps -> identical o_pixel/o_win_col sequence; o_win_valid never high on o_en_conv=0 follow-up cycles.
6. i_rst asserted mid-RUN (strip 1, col 2) -> next cycle all outputs 0, IDLE, o_knl_loaded=0; a subsequent i_frame_start is ignored until the kernel is reloaded.

Source files
------------

// File: rtl/conv_2d_ctrl.sv
// ---------------------------------------------------------------------------
// conv_2d_ctrl
//
// Sequencer for the conv_2d 3x3 convolution datapath. It loads the 3x3
// kernel column by column through the datapath's shared 3-lane data port,
// then streams image strips (three rows high, one 3-pixel column per beat).
// After each strip it inserts one zero "flush" column, which clocks the last
// window out of the datapath. It also produces a window-valid strobe and a
// column index. Both line up with the datapath's registered o_pixel.
//
// Ports
//   clk            system clock
//   i_rst          synchronous reset, active-high
//   i_knl_start    pulse: begin kernel load
//   i_knl_valid    kernel column valid
//   i_knl_c1..c3   signed coefficients, kernel rows 1..3 of current column
//   o_knl_ready    kernel column accepted when valid & ready
//   i_frame_start  pulse: begin frame (ignored until a kernel is resident)
//   i_pix_valid    pixel column valid
//   i_pix1..3      pixels, strip rows 1..3
//   o_pix_ready    pixel column accepted when valid & ready
//   o_load_knl     to datapath i_load_knl (registered)
//   o_en_conv      to datapath i_en_conv (registered)
//   o_data1..3     to datapath i_data1..3 (registered)
//   o_win_valid    datapath o_pixel holds a full 3x3 window this cycle
//   o_win_col      leftmost image column of that window
//   o_strip_done   one-cycle pulse, strip finished
//   o_frame_done   one-cycle pulse, frame finished
//   o_knl_loaded   kernel resident in the datapath
//   o_busy         sequencer not idle
// ---------------------------------------------------------------------------
module conv_2d_ctrl #(
  parameter int IMG_W      = 640,
  parameter int NUM_STRIPS = 478,
  parameter int COL_W      = $clog2(IMG_W + 1),
  parameter int STRIP_W    = $clog2(NUM_STRIPS + 1)
) (
  input  logic               clk,
  input  logic               i_rst,
  input  logic               i_knl_start,
  input  logic               i_knl_valid,
  input  logic signed [7:0]  i_knl_c1,
  input  logic signed [7:0]  i_knl_c2,
  input  logic signed [7:0]  i_knl_c3,
  output logic               o_knl_ready,
  input  logic               i_frame_start,
  input  logic               i_pix_valid,
  input  logic [7:0]         i_pix1,
  input  logic [7:0]         i_pix2,
  input  logic [7:0]         i_pix3,
  output logic               o_pix_ready,
  output logic               o_load_knl,
  output logic               o_en_conv,
  output logic [7:0]         o_data1,
  output logic [7:0]         o_data2,
  output logic [7:0]         o_data3,
  output logic               o_win_valid,
  output logic [COL_W-1:0]   o_win_col,
  output logic               o_strip_done,
  output logic               o_frame_done,
  output logic               o_knl_loaded,
  output logic               o_busy
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LOAD      = 3'd1;
  localparam logic [2:0] S_LOAD_WRAP = 3'd2;
  localparam logic [2:0] S_RUN       = 3'd3;
  localparam logic [2:0] S_FLUSH     = 3'd4;
  localparam logic [2:0] S_DONE      = 3'd5;

  localparam logic [COL_W-1:0]   C_ONE        = COL_W'(1);
  localparam logic [COL_W-1:0]   C_IMG_W      = COL_W'(IMG_W);
  localparam logic [COL_W-1:0]   C_LAST_COL   = COL_W'(IMG_W - 1);
  // The datapath window is 3 columns deep. The first three issues of a strip
  // only fill it, so no real window exists before then.
  localparam logic [COL_W-1:0]   C_WIN_LAG    = COL_W'(3);
  localparam logic [STRIP_W-1:0] C_ONE_S      = STRIP_W'(1);
  localparam logic [STRIP_W-1:0] C_LAST_STRIP = STRIP_W'(NUM_STRIPS - 1);

  logic [2:0]         r_state;
  logic [1:0]         r_knl_cnt;
  logic [COL_W-1:0]   r_col_cnt;
  logic [STRIP_W-1:0] r_strip_cnt;
  logic [COL_W-1:0]   r_issued;
  logic               r_load_knl;
  logic               r_en_conv;
  logic [7:0]         r_data1;
  logic [7:0]         r_data2;
  logic [7:0]         r_data3;
  logic               r_win_valid;
  logic [COL_W-1:0]   r_win_col;
  logic               r_strip_done;
  logic               r_frame_done;
  logic               r_knl_loaded;

  logic w_knl_acc;
  logic w_pix_acc;
  logic w_win_hit;

  assign o_knl_ready = (r_state == S_LOAD);
  assign o_pix_ready = (r_state == S_RUN) && (r_col_cnt < C_IMG_W);
  assign o_busy      = (r_state != S_IDLE);

  assign w_knl_acc = i_knl_valid && o_knl_ready;
  assign w_pix_acc = i_pix_valid && o_pix_ready;
  // The column being issued now pushes out the window that was already in
  // the datapath. That window appears on o_pixel in the next cycle.
  assign w_win_hit = r_en_conv && (r_issued >= C_WIN_LAG);

  assign o_load_knl   = r_load_knl;
  assign o_en_conv    = r_en_conv;
  assign o_data1      = r_data1;
  assign o_data2      = r_data2;
  assign o_data3      = r_data3;
  assign o_win_valid  = r_win_valid;
  assign o_win_col    = r_win_col;
  assign o_strip_done = r_strip_done;
  assign o_frame_done = r_frame_done;
  assign o_knl_loaded = r_knl_loaded;

  // NOTE: state is updated with non-blocking assignments only, so every
  // register sees the values from before the edge.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_knl_cnt    <= '0;
      r_col_cnt    <= '0;
      r_strip_cnt  <= '0;
      r_issued     <= '0;
      r_load_knl   <= 1'b0;
      r_en_conv    <= 1'b0;
      r_data1      <= '0;
      r_data2      <= '0;
      r_data3      <= '0;
      r_win_valid  <= 1'b0;
      r_win_col    <= '0;
      r_strip_done <= 1'b0;
      r_frame_done <= 1'b0;
      r_knl_loaded <= 1'b0;
    end else begin
      // Strobes default low. A cycle with no accepted beat holds the
      // datapath counters and window.
      r_load_knl   <= 1'b0;
      r_en_conv    <= 1'b0;
      r_strip_done <= 1'b0;
      r_frame_done <= 1'b0;

      r_win_valid <= w_win_hit;
      r_win_col   <= w_win_hit ? (r_issued - C_WIN_LAG) : '0;
      // r_strip_done is high exactly during the flush issue. That issue is
      // the last one of the strip, so the issue count restarts after it.
      if (r_en_conv) begin
        r_issued <= r_strip_done ? '0 : (r_issued + C_ONE);
      end

      case (r_state)
        S_IDLE: begin
          if (i_knl_start) begin
            r_state      <= S_LOAD;
            r_knl_cnt    <= '0;
            r_knl_loaded <= 1'b0;
          end else if (i_frame_start && r_knl_loaded) begin
            r_state     <= S_RUN;
            r_strip_cnt <= '0;
            r_col_cnt   <= '0;
          end
        end

        S_LOAD: begin
          if (w_knl_acc) begin
            r_load_knl <= 1'b1;
            r_data1    <= i_knl_c1;
            r_data2    <= i_knl_c2;
            r_data3    <= i_knl_c3;
            r_knl_cnt  <= r_knl_cnt + 2'd1;
            if (r_knl_cnt == 2'd2) begin
              r_state <= S_LOAD_WRAP;
            end
          end
        end

        // The datapath load counter runs 0..3 and sits at 3 after the third
        // column. One dummy load moves it back to 0 for the next load.
        S_LOAD_WRAP: begin
          r_load_knl   <= 1'b1;
          r_data1      <= '0;
          r_data2      <= '0;
          r_data3      <= '0;
          r_knl_loaded <= 1'b1;
          r_state      <= S_IDLE;
        end

        S_RUN: begin
          if (w_pix_acc) begin
            r_en_conv <= 1'b1;
            r_data1   <= i_pix1;
            r_data2   <= i_pix2;
            r_data3   <= i_pix3;
            r_col_cnt <= r_col_cnt + C_ONE;
            if (r_col_cnt == C_LAST_COL) begin
              r_state <= S_FLUSH;
            end
          end
        end

        S_FLUSH: begin
          r_en_conv    <= 1'b1;
          r_data1      <= '0;
          r_data2      <= '0;
          r_data3      <= '0;
          r_col_cnt    <= '0;
          r_strip_done <= 1'b1;
          if (r_strip_cnt == C_LAST_STRIP) begin
            r_state <= S_DONE;
          end else begin
            r_strip_cnt <= r_strip_cnt + C_ONE_S;
            r_state     <= S_RUN;
          end
        end

        S_DONE: begin
          r_frame_done <= 1'b1;
          r_state      <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_2d_ctrl.sv
// ---------------------------------------------------------------------------
// tb_conv_2d_ctrl
//
// Directed bench for conv_2d_ctrl with IMG_W=5 and NUM_STRIPS=2. A
// behavioural conv_2d model is driven from the controller outputs. It holds
// a 0..3 load counter, a 3x3 kernel, a 3-column window and a registered
// o_pixel. The bench compares what the model observes against values worked
// out by hand.
// ---------------------------------------------------------------------------
module tb_conv_2d_ctrl;

  localparam int W  = 5;
  localparam int NS = 2;
  localparam int CW = $clog2(W + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              i_rst;
  logic              i_knl_start;
  logic              i_knl_valid;
  logic signed [7:0] i_knl_c1, i_knl_c2, i_knl_c3;
  logic              o_knl_ready;
  logic              i_frame_start;
  logic              i_pix_valid;
  logic [7:0]        i_pix1, i_pix2, i_pix3;
  logic              o_pix_ready;
  logic              o_load_knl;
  logic              o_en_conv;
  logic [7:0]        o_data1, o_data2, o_data3;
  logic              o_win_valid;
  logic [CW-1:0]     o_win_col;
  logic              o_strip_done;
  logic              o_frame_done;
  logic              o_knl_loaded;
  logic              o_busy;

  conv_2d_ctrl #(.IMG_W(W), .NUM_STRIPS(NS)) dut (
    .clk          (clk),
    .i_rst        (i_rst),
    .i_knl_start  (i_knl_start),
    .i_knl_valid  (i_knl_valid),
    .i_knl_c1     (i_knl_c1),
    .i_knl_c2     (i_knl_c2),
    .i_knl_c3     (i_knl_c3),
    .o_knl_ready  (o_knl_ready),
    .i_frame_start(i_frame_start),
    .i_pix_valid  (i_pix_valid),
    .i_pix1       (i_pix1),
    .i_pix2       (i_pix2),
    .i_pix3       (i_pix3),
    .o_pix_ready  (o_pix_ready),
    .o_load_knl   (o_load_knl),
    .o_en_conv    (o_en_conv),
    .o_data1      (o_data1),
    .o_data2      (o_data2),
    .o_data3      (o_data3),
    .o_win_valid  (o_win_valid),
    .o_win_col    (o_win_col),
    .o_strip_done (o_strip_done),
    .o_frame_done (o_frame_done),
    .o_knl_loaded (o_knl_loaded),
    .o_busy       (o_busy)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // ---------------- datapath model and event monitor (negedge) -------------
  logic signed [7:0] k [3][3];
  int  win [3][3];
  int  ld_cnt, dp_pixel, acc_sum;
  int  load_cycles, cur_run, max_run, en_cycles, strip_dones, frame_dones;
  int  overlap, bad_win, accepts;
  bit  prev_en;
  int  q_col[$];
  int  q_pix[$];

  always @(negedge clk) begin
    if (i_rst) begin
      ld_cnt   = 0;
      dp_pixel = 0;
      prev_en  = 1'b0;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          k[r][c]   = '0;
          win[r][c] = 0;
        end
      end
    end else begin
      // o_pixel as it stands in this cycle, before any issue below updates it.
      if (o_win_valid) begin
        q_col.push_back(int'(o_win_col));
        q_pix.push_back(dp_pixel);
        if (!prev_en) bad_win++;
      end
      if (o_load_knl) begin
        if (ld_cnt < 3) begin
          k[0][ld_cnt] = o_data1;
          k[1][ld_cnt] = o_data2;
          k[2][ld_cnt] = o_data3;
        end
        ld_cnt = (ld_cnt + 1) % 4;
        load_cycles++;
        cur_run++;
        if (cur_run > max_run) max_run = cur_run;
      end else begin
        cur_run = 0;
      end
      if (o_en_conv) begin
        acc_sum = 0;
        for (int r = 0; r < 3; r++) begin
          for (int c = 0; c < 3; c++) acc_sum += int'(k[r][c]) * win[r][c];
        end
        dp_pixel = acc_sum;
        for (int r = 0; r < 3; r++) begin
          win[r][0] = win[r][1];
          win[r][1] = win[r][2];
        end
        win[0][2] = int'(o_data1);
        win[1][2] = int'(o_data2);
        win[2][2] = int'(o_data3);
        en_cycles++;
      end
      if (o_en_conv && o_load_knl) overlap++;
      if (o_strip_done) strip_dones++;
      if (o_frame_done) frame_dones++;
      prev_en = o_en_conv;
    end
  end

  // ---------------- helpers -------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_stats();
    load_cycles = 0; cur_run = 0; max_run = 0; en_cycles = 0;
    strip_dones = 0; frame_dones = 0; overlap = 0; bad_win = 0; accepts = 0;
    q_col.delete();
    q_pix.delete();
  endtask

  task automatic send_knl(input int c1, input int c2, input int c3);
    int n;
    i_knl_valid = 1'b1;
    i_knl_c1 = 8'(c1); i_knl_c2 = 8'(c2); i_knl_c3 = 8'(c3);
    n = 0;
    while (!o_knl_ready && n < 20) begin tick(); n++; end
    check("knl_ready_at_accept", 32'(o_knl_ready), 32'd1);
    tick();
  endtask

  task automatic wait_loaded();
    int n;
    n = 0;
    while (!o_knl_loaded && n < 20) begin tick(); n++; end
    check("knl_loaded", 32'(o_knl_loaded), 32'd1);
    check("idle_after_load", 32'(o_busy), 32'd0);
  endtask

  function automatic int mid_pix(input int s, input int c);
    return 10 * s + c + 1;
  endfunction

  task automatic send_pix(input int s, input int c, input bit gaps);
    int n;
    if (gaps) begin
      i_pix_valid = 1'b0;
      repeat ($urandom_range(0, 2)) tick();
    end
    i_pix1 = 8'(40 + 10 * s + c);
    i_pix2 = 8'(mid_pix(s, c));
    i_pix3 = 8'(80 + 10 * s + c);
    i_pix_valid = 1'b1;
    n = 0;
    while (!o_pix_ready && n < 20) begin tick(); n++; end
    check("pix_ready_at_accept", 32'(o_pix_ready), 32'd1);
    tick();
    accepts++;
  endtask

  task automatic load_identity();
    i_knl_start = 1'b1; tick(); i_knl_start = 1'b0;
    send_knl(0, 0, 0);
    send_knl(0, 1, 0);
    send_knl(0, 0, 0);
    i_knl_valid = 1'b0;
    wait_loaded();
    repeat (2) tick();
  endtask

  task automatic run_frame(input bit gaps);
    int n;
    clear_stats();
    i_frame_start = 1'b1; tick(); i_frame_start = 1'b0;
    check("run_busy", 32'(o_busy), 32'd1);
    check("run_pix_ready", 32'(o_pix_ready), 32'd1);
    for (int s = 0; s < NS; s++) begin
      for (int c = 0; c < W; c++) send_pix(s, c, gaps);
    end
    i_pix_valid = 1'b0;
    n = 0;
    while (!o_frame_done && n < 50) begin tick(); n++; end
    check("frame_done_seen", 32'(o_frame_done), 32'd1);
    repeat (3) tick();
    check("frame_idle", 32'(o_busy), 32'd0);
    check("accepts", 32'(accepts), 32'(NS * W));
    check("en_conv_cycles", 32'(en_cycles), 32'(NS * (W + 1)));
    check("strip_done_pulses", 32'(strip_dones), 32'(NS));
    check("frame_done_pulses", 32'(frame_dones), 32'd1);
    check("load_en_overlap", 32'(overlap), 32'd0);
    check("win_without_issue", 32'(bad_win), 32'd0);
    check("win_count", 32'(q_col.size()), 32'(NS * (W - 2)));
    for (int i = 0; i < NS * (W - 2); i++) begin
      if (i < q_col.size()) begin
        check("win_col", 32'(q_col[i]), 32'(i % (W - 2)));
        check("win_pixel", 32'(q_pix[i]), 32'(mid_pix(i / (W - 2), i % (W - 2) + 1)));
      end
    end
  endtask

  // ---------------- directed sequence ---------------------------------------
  initial begin
    i_rst = 1'b1; i_knl_start = 1'b0; i_knl_valid = 1'b0;
    i_knl_c1 = '0; i_knl_c2 = '0; i_knl_c3 = '0;
    i_frame_start = 1'b0; i_pix_valid = 1'b0;
    i_pix1 = '0; i_pix2 = '0; i_pix3 = '0;
    clear_stats();
    repeat (3) tick();

    // Reset state
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_knl_ready", 32'(o_knl_ready), 32'd0);
    check("rst_pix_ready", 32'(o_pix_ready), 32'd0);
    check("rst_load_knl", 32'(o_load_knl), 32'd0);
    check("rst_en_conv", 32'(o_en_conv), 32'd0);
    check("rst_win_valid", 32'(o_win_valid), 32'd0);
    check("rst_win_col", 32'(o_win_col), 32'd0);
    check("rst_strip_done", 32'(o_strip_done), 32'd0);
    check("rst_frame_done", 32'(o_frame_done), 32'd0);
    check("rst_knl_loaded", 32'(o_knl_loaded), 32'd0);
    check("rst_data", 32'({o_data1, o_data2, o_data3}), 32'd0);
    i_rst = 1'b0;
    tick();

    // Frame start with no kernel resident is ignored
    i_frame_start = 1'b1; tick(); i_frame_start = 1'b0;
    check("nokernel_busy", 32'(o_busy), 32'd0);
    check("nokernel_pix_ready", 32'(o_pix_ready), 32'd0);
    tick();
    check("nokernel_busy_later", 32'(o_busy), 32'd0);

    // Kernel load, back-to-back columns
    clear_stats();
    i_knl_start = 1'b1; tick(); i_knl_start = 1'b0;
    check("load_knl_ready", 32'(o_knl_ready), 32'd1);
    check("load_busy", 32'(o_busy), 32'd1);
    send_knl(1, 4, 7);
    send_knl(2, 5, 8);
    send_knl(3, 6, 9);
    i_knl_valid = 1'b0;
    wait_loaded();
    repeat (2) tick();
    check("load_cycles", 32'(load_cycles), 32'd4);
    check("load_run", 32'(max_run), 32'd4);
    for (int i = 0; i < 9; i++) check("kernel_a", 32'(int'(k[i / 3][i % 3])), 32'(i + 1));

    // Both starts together: LOAD wins; 2-cycle gap after the first column
    clear_stats();
    i_knl_start = 1'b1; i_frame_start = 1'b1; tick();
    i_knl_start = 1'b0; i_frame_start = 1'b0;
    check("both_knl_ready", 32'(o_knl_ready), 32'd1);
    check("both_pix_ready", 32'(o_pix_ready), 32'd0);
    check("reload_clears_loaded", 32'(o_knl_loaded), 32'd0);
    send_knl(1, 4, 7);
    i_knl_valid = 1'b0;
    repeat (2) tick();
    send_knl(2, 5, 8);
    send_knl(3, 6, 9);
    i_knl_valid = 1'b0;
    wait_loaded();
    repeat (2) tick();
    check("gap_load_cycles", 32'(load_cycles), 32'd4);
    check("gap_load_run", 32'(max_run), 32'd3);
    for (int i = 0; i < 9; i++) check("kernel_b", 32'(int'(k[i / 3][i % 3])), 32'(i + 1));

    // Identity kernel; continuous frame, then a frame with random gaps
    load_identity();
    run_frame(1'b0);
    run_frame(1'b1);

    // Reset in strip 1 at column 2
    clear_stats();
    i_frame_start = 1'b1; tick(); i_frame_start = 1'b0;
    for (int c = 0; c < W; c++) send_pix(0, c, 1'b0);
    send_pix(1, 0, 1'b0);
    send_pix(1, 1, 1'b0);
    i_pix_valid = 1'b0;
    check("midrun_busy", 32'(o_busy), 32'd1);
    i_rst = 1'b1; tick();
    check("abort_busy", 32'(o_busy), 32'd0);
    check("abort_knl_loaded", 32'(o_knl_loaded), 32'd0);
    check("abort_en_conv", 32'(o_en_conv), 32'd0);
    check("abort_load_knl", 32'(o_load_knl), 32'd0);
    check("abort_pix_ready", 32'(o_pix_ready), 32'd0);
    check("abort_win_valid", 32'(o_win_valid), 32'd0);
    check("abort_data", 32'({o_data1, o_data2, o_data3}), 32'd0);
    i_rst = 1'b0; tick();
    i_frame_start = 1'b1; tick(); i_frame_start = 1'b0;
    check("abort_start_ignored", 32'(o_busy), 32'd0);
    check("abort_pix_ready_later", 32'(o_pix_ready), 32'd0);

    // Recovery after reload
    load_identity();
    run_frame(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
